// File: rtl/charlie7x5_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : charlie7x5_pkg
//  Description : Shared constants, scan state type and pin mapping helper
//                for the 7x5 charlieplexed LED matrix scanner.
//  Revision    : 1.0 - initial release
// ============================================================================
package charlie7x5_pkg;

    localparam int          NPINS         = 7;
    localparam int          NCOLS         = 5;
    localparam int          NROWS         = 7;
    localparam logic [2:0]  ADR_CTRL      = 3'd7;
    localparam int          CTRL_SWAP_BIT = 0;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    // Column c of row r sinks current through the pin c+1 places after the anode.
    function automatic logic [2:0] cathode_pin(input logic [2:0] r, input int c);
        int s;
        s = (int'(r) + 1 + c) % NPINS;
        return 3'(s);
    endfunction

endpackage
`default_nettype wire

// File: rtl/charlie7x5_scan_if.sv
`default_nettype none
// ============================================================================
//  Module      : charlie7x5_scan_if
//  Description : Classic Wishbone slave port bundle for the matrix scanner.
//  Revision    : 1.0 - initial release
// ============================================================================
interface charlie7x5_scan_if;

    logic       wb_stb_i;
    logic       wb_we_i;
    logic [2:0] wb_adr_i;
    logic [7:0] wb_dat_i;
    logic [7:0] wb_dat_o;
    logic       wb_ack_o;

    modport master (
        output wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        output wb_dat_o, wb_ack_o
    );

endinterface
`default_nettype wire

// File: rtl/charlie7x5_row_decode.sv
`default_nettype none
// ============================================================================
//  Module      : charlie7x5_row_decode
//  Description : Combinational map from one row's column bits to the
//                7-pin output-enable / level vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module charlie7x5_row_decode
    import charlie7x5_pkg::*;
(
    input  wire logic [2:0]       i_row,
    input  wire logic [NCOLS-1:0] i_cols,
    output logic      [NPINS-1:0] o_oe,
    output logic      [NPINS-1:0] o_o
);

    always_comb begin
        o_oe        = '0;
        o_o         = '0;
        o_oe[i_row] = 1'b1;
        o_o[i_row]  = 1'b1;
        for (int c = 0; c < NCOLS; c++) begin
            if (i_cols[c]) begin
                o_oe[cathode_pin(i_row, c)] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/charlie7x5_scan.sv
`default_nettype none
// ============================================================================
//  Module      : charlie7x5_scan
//  Description : Double-buffered 7x5 charlieplex scanner with blanking and a
//                Wishbone back-buffer port; swaps only at frame boundaries.
//  Revision    : 1.0 - initial release
// ============================================================================
module charlie7x5_scan
    import charlie7x5_pkg::*;
#(
    parameter int ON_TICKS    = 1000,
    parameter int BLANK_TICKS = 16
) (
    input  wire logic             clock,
    input  wire logic             reset_n,
    charlie7x5_scan_if.slave      wb,
    output logic      [NPINS-1:0] charlie7x5_oe,
    output logic      [NPINS-1:0] charlie7x5_o,
    output logic                  frame_start
);

    localparam int c_max_ticks = (ON_TICKS > BLANK_TICKS) ? ON_TICKS : BLANK_TICKS;
    localparam int c_cnt_w     = (c_max_ticks > 1) ? $clog2(c_max_ticks) : 1;
    localparam logic [c_cnt_w-1:0] c_on_last    = c_cnt_w'(ON_TICKS - 1);
    localparam logic [c_cnt_w-1:0] c_blank_last = c_cnt_w'(BLANK_TICKS - 1);
    localparam logic [2:0]         c_last_row   = 3'(NROWS - 1);

    state_t             r_state;
    logic [2:0]         r_row;
    logic [c_cnt_w-1:0] r_cnt;
    logic [NPINS-1:0]   r_oe;
    logic [NPINS-1:0]   r_o;
    logic               r_frame_start;
    logic [NCOLS-1:0]   r_back  [NROWS];
    logic [NCOLS-1:0]   r_front [NROWS];
    logic               r_pending;
    logic               r_ack;
    logic [7:0]         r_dat;

    logic               w_xfer;
    logic               w_ctrl;
    logic               w_swap_req;
    logic               w_row_wr;
    logic               w_boundary;
    logic [7:0]         w_rdata;
    logic [NPINS-1:0]   w_dec_oe;
    logic [NPINS-1:0]   w_dec_o;
    logic               w_unused_dat_bits;

    assign w_xfer            = wb.wb_stb_i & ~r_ack;
    assign w_ctrl            = (wb.wb_adr_i == ADR_CTRL);
    assign w_swap_req        = w_xfer & wb.wb_we_i & w_ctrl & wb.wb_dat_i[CTRL_SWAP_BIT];
    assign w_row_wr          = w_xfer & wb.wb_we_i & ~w_ctrl;
    assign w_boundary        = (r_state == DRIVE) && (r_cnt == c_on_last) && (r_row == c_last_row);
    assign w_unused_dat_bits = ^wb.wb_dat_i[7:5];

    always_comb begin
        w_rdata = '0;
        if (w_ctrl) begin
            w_rdata = {7'b0, r_pending};
        end else begin
            w_rdata = {3'b0, r_back[wb.wb_adr_i]};
        end
    end

    charlie7x5_row_decode u_row_decode (
        .i_row  (r_row),
        .i_cols (r_front[r_row]),
        .o_oe   (w_dec_oe),
        .o_o    (w_dec_o)
    );

    // A swap request landing on the boundary edge both copies now and stays pending.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NROWS; i++) begin
                r_back[i]  <= '0;
                r_front[i] <= '0;
            end
            r_pending <= 1'b0;
            r_ack     <= 1'b0;
            r_dat     <= '0;
        end else begin
            r_ack <= w_xfer;
            r_dat <= '0;
            if (w_xfer && !wb.wb_we_i) begin
                r_dat <= w_rdata;
            end
            if (w_row_wr) begin
                r_back[wb.wb_adr_i] <= wb.wb_dat_i[NCOLS-1:0];
            end
            if (w_boundary && (r_pending || w_swap_req)) begin
                for (int i = 0; i < NROWS; i++) begin
                    r_front[i] <= r_back[i];
                end
            end
            if (w_swap_req) begin
                r_pending <= 1'b1;
            end else if (w_boundary) begin
                r_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= BLANK;
            r_row         <= '0;
            r_cnt         <= '0;
            r_oe          <= '0;
            r_o           <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            case (r_state)
                BLANK: begin
                    if (r_cnt == c_blank_last) begin
                        r_state <= DRIVE;
                        r_cnt   <= '0;
                        r_oe    <= w_dec_oe;
                        r_o     <= w_dec_o;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DRIVE: begin
                    if (r_cnt == c_on_last) begin
                        r_state <= BLANK;
                        r_cnt   <= '0;
                        r_oe    <= '0;
                        r_o     <= '0;
                        if (r_row == c_last_row) begin
                            r_row         <= '0;
                            r_frame_start <= 1'b1;
                        end else begin
                            r_row <= r_row + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= BLANK;
                    r_cnt   <= '0;
                    r_oe    <= '0;
                    r_o     <= '0;
                end
            endcase
        end
    end

    assign charlie7x5_oe = r_oe;
    assign charlie7x5_o  = r_o;
    assign frame_start   = r_frame_start;
    assign wb.wb_ack_o   = r_ack;
    assign wb.wb_dat_o   = r_dat;

endmodule
`default_nettype wire

// File: tb/tb_charlie7x5_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_charlie7x5_scan
//  Description : Self-checking bench for charlie7x5_scan with a frame-level
//                reference model and directed scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_charlie7x5_scan;

    localparam int ON    = 4;
    localparam int BL    = 2;
    localparam int RP    = ON + BL;
    localparam int FRAME = 7 * RP;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic [6:0] oe;
    logic [6:0] o;
    logic       fs;

    always #5 clock = ~clock;

    charlie7x5_scan_if wb_if ();

    charlie7x5_scan #(
        .ON_TICKS    (ON),
        .BLANK_TICKS (BL)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .wb            (wb_if),
        .charlie7x5_oe (oe),
        .charlie7x5_o  (o),
        .frame_start   (fs)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: time since reset release plus software-visible buffers.
    int         m_t       = 0;
    logic [4:0] m_back  [7] = '{default: 5'd0};
    logic [4:0] m_front [7] = '{default: 5'd0};
    bit         m_pending = 1'b0;
    bit         m_ack     = 1'b0;
    bit         m_rd      = 1'b0;
    logic [7:0] m_dat     = 8'h00;

    always @(posedge clock or negedge reset_n) begin : model
        bit   xfer;
        bit   swap_req;
        bit   old_pending;
        if (!reset_n) begin
            m_t       = 0;
            m_pending = 1'b0;
            m_ack     = 1'b0;
            m_rd      = 1'b0;
            m_dat     = 8'h00;
            for (int i = 0; i < 7; i++) begin
                m_back[i]  = 5'd0;
                m_front[i] = 5'd0;
            end
        end else begin
            xfer        = wb_if.wb_stb_i && !m_ack;
            swap_req    = xfer && wb_if.wb_we_i && (wb_if.wb_adr_i == 3'd7) && wb_if.wb_dat_i[0];
            old_pending = m_pending;
            m_rd        = xfer && !wb_if.wb_we_i;
            if (m_rd) begin
                m_dat = (wb_if.wb_adr_i == 3'd7) ? {7'b0, old_pending} : {3'b0, m_back[wb_if.wb_adr_i]};
            end
            if ((m_t + 1) % FRAME == 0) begin
                if (old_pending || swap_req) begin
                    for (int i = 0; i < 7; i++) m_front[i] = m_back[i];
                end
                m_pending = 1'b0;
            end
            if (xfer && wb_if.wb_we_i) begin
                if (wb_if.wb_adr_i == 3'd7) begin
                    if (wb_if.wb_dat_i[0]) m_pending = 1'b1;
                end else begin
                    m_back[wb_if.wb_adr_i] = wb_if.wb_dat_i[4:0];
                end
            end
            m_ack = xfer;
            m_t   = m_t + 1;
        end
    end

    function automatic void exp_pins(input int t, output logic [6:0] eoe, output logic [6:0] eo);
        int row;
        int ph;
        row = (t / RP) % 7;
        ph  = t % RP;
        eoe = '0;
        eo  = '0;
        if (ph >= BL) begin
            eoe[row] = 1'b1;
            eo[row]  = 1'b1;
            for (int c = 0; c < 5; c++) begin
                if (m_front[row][c]) eoe[(row + 1 + c) % 7] = 1'b1;
            end
        end
    endfunction

    always @(negedge clock) begin : compare
        logic [6:0] eoe;
        logic [6:0] eo;
        if (!reset_n) begin
            chk("oe_in_reset", oe, 0);
            chk("o_in_reset", o, 0);
            chk("fs_in_reset", fs, 0);
            chk("ack_in_reset", wb_if.wb_ack_o, 0);
        end else begin
            exp_pins(m_t, eoe, eo);
            chk("oe", oe, eoe);
            chk("o", o, eo);
            chk("frame_start", fs, (m_t > 0) && (m_t % FRAME == 0));
            chk("ack", wb_if.wb_ack_o, m_ack);
            if (m_ack && m_rd) chk("rdata", wb_if.wb_dat_o, m_dat);
        end
    end

    task automatic wait_fs(output int n);
        n = 0;
        forever begin
            @(negedge clock);
            n++;
            if (fs === 1'b1) break;
            if (n >= 200) begin
                chk("frame_start_timeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic wb_do(input bit we, input logic [2:0] adr, input logic [7:0] dat,
                         input bit hold, output logic [7:0] rd);
        @(negedge clock);
        wb_if.wb_stb_i = 1'b1;
        wb_if.wb_we_i  = we;
        wb_if.wb_adr_i = adr;
        wb_if.wb_dat_i = dat;
        @(negedge clock);
        chk("ack_rise", wb_if.wb_ack_o, 1);
        rd = wb_if.wb_dat_o;
        if (hold) begin
            @(negedge clock);
            chk("ack_low_stb_high", wb_if.wb_ack_o, 0);
        end
        wb_if.wb_stb_i = 1'b0;
        wb_if.wb_we_i  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : directed
        int         n;
        logic [7:0] rd;
        wb_if.wb_stb_i = 1'b0;
        wb_if.wb_we_i  = 1'b0;
        wb_if.wb_adr_i = 3'd0;
        wb_if.wb_dat_i = 8'h00;

        // Reset and first rows
        repeat (3) @(negedge clock);
        #2 reset_n = 1'b1;
        @(negedge clock);
        chk("blank_after_reset_oe", oe, 7'b0000000);
        @(negedge clock);
        chk("row0_first_oe", oe, 7'b0000001);
        chk("row0_first_o", o, 7'b0000001);
        wait_fs(n);
        chk("first_frame_start_cycles", n, 40);
        wait_fs(n);
        chk("frame_period", n, 42);

        // Back-buffer write without swap leaves the display alone
        wb_do(1'b1, 3'd0, 8'hF5, 1'b0, rd);
        wb_do(1'b0, 3'd0, 8'h00, 1'b1, rd);
        chk("read_adr0", rd, 8'h15);
        for (int k = 0; k < 2; k++) begin
            wait_fs(n);
            repeat (2) @(negedge clock);
            chk("row0_unchanged_oe", oe, 7'b0000001);
        end

        // Swap request, pending readback, cleared at boundary
        wb_do(1'b1, 3'd7, 8'h01, 1'b0, rd);
        wb_do(1'b0, 3'd7, 8'h00, 1'b0, rd);
        chk("pending_set", rd, 8'h01);
        wait_fs(n);
        wb_do(1'b0, 3'd7, 8'h00, 1'b0, rd);
        chk("pending_cleared", rd, 8'h00);
        chk("row0_swapped_oe", oe, 7'b0101011);
        chk("row0_swapped_o", o, 7'b0000001);

        // Row 6 wraps its cathodes past pin 6
        wb_do(1'b1, 3'd6, 8'h01, 1'b0, rd);
        wb_do(1'b1, 3'd7, 8'h01, 1'b0, rd);
        wait_fs(n);
        repeat (38) @(negedge clock);
        chk("row6_one_oe", oe, 7'b1000001);
        chk("row6_one_o", o, 7'b1000000);
        wb_do(1'b1, 3'd6, 8'h1F, 1'b0, rd);
        wb_do(1'b1, 3'd7, 8'h01, 1'b0, rd);
        wait_fs(n);
        repeat (38) @(negedge clock);
        chk("row6_full_oe", oe, 7'b1011111);
        chk("row6_full_o", o, 7'b1000000);

        // Swap acked on the boundary cycle
        wait_fs(n);
        wb_do(1'b1, 3'd5, 8'h1F, 1'b0, rd);
        repeat (38) @(negedge clock);
        wb_do(1'b1, 3'd7, 8'h01, 1'b0, rd);
        chk("swap_ack_on_fs", fs, 1);
        wb_do(1'b0, 3'd7, 8'h00, 1'b0, rd);
        chk("pending_after_boundary_swap", rd, 8'h01);
        repeat (30) @(negedge clock);
        chk("row5_full_oe", oe, 7'b1101111);
        chk("row5_full_o", o, 7'b0100000);
        wait_fs(n);
        wb_do(1'b0, 3'd7, 8'h00, 1'b0, rd);
        chk("pending_cleared_next_frame", rd, 8'h00);

        // Asynchronous reset mid-DRIVE of row 3
        wait_fs(n);
        repeat (21) @(negedge clock);
        chk("row3_before_reset_oe", oe, 7'b0001000);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_oe", oe, 7'b0000000);
        chk("async_reset_o", o, 7'b0000000);
        @(negedge clock);
        #2 reset_n = 1'b1;
        @(negedge clock);
        chk("restart_blank_oe", oe, 7'b0000000);
        @(negedge clock);
        chk("restart_row0_oe", oe, 7'b0000001);
        for (int a = 0; a < 7; a++) begin
            wb_do(1'b0, 3'(a), 8'h00, 1'b0, rd);
            chk("back_cleared", rd, 8'h00);
        end

        repeat (2) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
